// File: rtl/anycore_l15_req_arbiter.sv
// Funnels AnyCore I-miss, D-load and store pulses onto the single L1.5 request port,
// one outstanding transaction at a time, with round-robin fairness across sources.
module anycore_l15_req_arbiter #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imiss_val,
    input  logic [ADDR_W-1:0] imiss_addr,
    output logic              imiss_busy,
    input  logic              ld_val,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_busy,
    input  logic              st_val,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_size,
    output logic              st_busy,
    output logic              l15_val,
    output logic [4:0]        l15_rqtype,
    output logic [ADDR_W-1:0] l15_address,
    output logic [DATA_W-1:0] l15_data,
    output logic [2:0]        l15_size,
    input  logic              l15_ack,
    input  logic              l15_resp_val,
    output logic              resp_fire,
    output logic [1:0]        resp_src,
    output logic [2:0]        overflow
);

    localparam logic [4:0] IMISS_RQ  = 5'b10000;
    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] STORE_RQ  = 5'b00001;
    localparam logic [2:0] PCX_SZ_4B = 3'b010;

    localparam logic [1:0] SRC_I = 2'd0;
    localparam logic [1:0] SRC_L = 2'd1;
    localparam logic [1:0] SRC_S = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [2:0]        pending;
    logic [ADDR_W-1:0] i_addr, l_addr, s_addr;
    logic [DATA_W-1:0] s_data;
    logic [2:0]        s_size;
    logic [1:0]        last_grant;
    logic [1:0]        grant_src;

    logic [2:0] req_val;
    logic       acked;
    logic [2:0] clr;
    logic [2:0] capture;
    logic [2:0] drop;
    logic       grant_ok;
    logic [1:0] grant_idx;

    assign req_val = {st_val, ld_val, imiss_val};
    assign acked   = (state == S_REQ) && l15_ack;

    // A slot being acked this cycle may be refilled by a same-cycle pulse.
    always_comb begin
        clr = '0;
        if (acked) begin
            clr[grant_src] = 1'b1;
        end
        capture = req_val & (~pending | clr);
        drop    = req_val & pending & ~clr;
    end

    always_comb begin
        int unsigned cand;
        grant_ok  = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = (32'(last_grant) + k) % 3;
            if (!grant_ok && pending[cand]) begin
                grant_ok  = 1'b1;
                grant_idx = cand[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_ok) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (l15_ack) begin
                    state_next = (grant_src == SRC_S) ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (l15_resp_val) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            overflow    <= '0;
            last_grant  <= SRC_S;
            grant_src   <= SRC_I;
            i_addr      <= '0;
            l_addr      <= '0;
            s_addr      <= '0;
            s_data      <= '0;
            s_size      <= '0;
            l15_val     <= 1'b0;
            l15_rqtype  <= '0;
            l15_address <= '0;
            l15_data    <= '0;
            l15_size    <= '0;
        end else begin
            pending  <= (pending & ~clr) | capture;
            overflow <= overflow | drop;
            if (capture[0]) begin
                i_addr <= imiss_addr;
            end
            if (capture[1]) begin
                l_addr <= ld_addr;
            end
            if (capture[2]) begin
                s_addr <= st_addr;
                s_data <= st_data;
                s_size <= st_size;
            end

            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        l15_val    <= 1'b1;
                        last_grant <= grant_idx;
                        grant_src  <= grant_idx;
                        case (grant_idx)
                            SRC_I: begin
                                l15_rqtype  <= IMISS_RQ;
                                l15_address <= i_addr;
                                l15_data    <= '0;
                                l15_size    <= PCX_SZ_4B;
                            end
                            SRC_L: begin
                                l15_rqtype  <= LOAD_RQ;
                                l15_address <= l_addr;
                                l15_data    <= '0;
                                l15_size    <= PCX_SZ_4B;
                            end
                            default: begin
                                l15_rqtype  <= STORE_RQ;
                                l15_address <= s_addr;
                                l15_data    <= s_data;
                                l15_size    <= s_size;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    if (l15_ack) begin
                        l15_val     <= 1'b0;
                        l15_rqtype  <= '0;
                        l15_address <= '0;
                        l15_data    <= '0;
                        l15_size    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imiss_busy = pending[0];
    assign ld_busy    = pending[1];
    assign st_busy    = pending[2];
    assign resp_fire  = (state == S_WAIT) && l15_resp_val;
    assign resp_src   = resp_fire ? grant_src : '0;

endmodule

// File: tb/tb_anycore_l15_req_arbiter.sv
// Bench for anycore_l15_req_arbiter: directed scenarios plus a transaction-level
// reference model compared against the DUT outputs on every cycle.
module tb_anycore_l15_req_arbiter;

    localparam int AW = 40;
    localparam int DW = 64;

    localparam logic [4:0] RQ_IMISS = 5'b10000;
    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;

    logic          clk;
    logic          rst;
    logic          imiss_val, ld_val, st_val;
    logic [AW-1:0] imiss_addr, ld_addr, st_addr;
    logic [DW-1:0] st_data;
    logic [2:0]    st_size;
    logic          imiss_busy, ld_busy, st_busy;
    logic          l15_val;
    logic [4:0]    l15_rqtype;
    logic [AW-1:0] l15_address;
    logic [DW-1:0] l15_data;
    logic [2:0]    l15_size;
    logic          l15_ack, l15_resp_val;
    logic          resp_fire;
    logic [1:0]    resp_src;
    logic [2:0]    overflow;

    anycore_l15_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .imiss_val(imiss_val), .imiss_addr(imiss_addr), .imiss_busy(imiss_busy),
        .ld_val(ld_val), .ld_addr(ld_addr), .ld_busy(ld_busy),
        .st_val(st_val), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_busy(st_busy),
        .l15_val(l15_val), .l15_rqtype(l15_rqtype), .l15_address(l15_address),
        .l15_data(l15_data), .l15_size(l15_size), .l15_ack(l15_ack),
        .l15_resp_val(l15_resp_val), .resp_fire(resp_fire), .resp_src(resp_src),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: per-source request slots and one in-flight transaction
    logic [2:0]    m_pend;
    logic [AW-1:0] m_slot_addr[3];
    logic [DW-1:0] m_slot_data;
    logic [2:0]    m_slot_size;
    int            m_phase;   // 0 free, 1 presented, 2 awaiting response
    int            m_src, m_last;
    logic [2:0]    m_ovf;
    logic          m_val;
    logic [4:0]    m_rq;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic [2:0]    m_sz;
    bit            chk_en = 0;

    always @(posedge clk) begin : model
        logic [2:0] v;
        logic [2:0] np;
        bit acked;
        int c;
        v = {st_val, ld_val, imiss_val};
        if (rst) begin
            m_pend = 0; m_ovf = 0; m_phase = 0; m_src = 0; m_last = 2;
            m_val = 0; m_rq = 0; m_a = 0; m_d = 0; m_sz = 0;
            m_slot_addr[0] = 0; m_slot_addr[1] = 0; m_slot_addr[2] = 0;
            m_slot_data = 0; m_slot_size = 0;
            chk_en = 1;
        end else begin
            acked = (m_phase == 1) && l15_ack;
            np = m_pend;
            if (acked) np[m_src] = 1'b0;
            if (m_phase == 0 && m_pend != 0) begin
                for (int k = 1; k <= 3; k++) begin
                    c = (m_last + k) % 3;
                    if (m_pend[c]) break;
                end
                m_val = 1;
                m_rq  = (c == 0) ? RQ_IMISS : (c == 1) ? RQ_LOAD : RQ_STORE;
                m_a   = m_slot_addr[c];
                m_d   = (c == 2) ? m_slot_data : '0;
                m_sz  = (c == 2) ? m_slot_size : 3'b010;
                m_src = c; m_last = c; m_phase = 1;
            end else if (m_phase == 1 && l15_ack) begin
                m_val = 0; m_rq = 0; m_a = 0; m_d = 0; m_sz = 0;
                m_phase = (m_src == 2) ? 0 : 2;
            end else if (m_phase == 2 && l15_resp_val) begin
                m_phase = 0;
            end
            for (int x = 0; x < 3; x++) begin
                if (v[x]) begin
                    if (!np[x]) begin
                        np[x] = 1'b1;
                        m_slot_addr[x] = (x == 0) ? imiss_addr : (x == 1) ? ld_addr : st_addr;
                        if (x == 2) begin
                            m_slot_data = st_data;
                            m_slot_size = st_size;
                        end
                    end else begin
                        m_ovf[x] = 1'b1;
                    end
                end
            end
            m_pend = np;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_busy",     {st_busy, ld_busy, imiss_busy}, m_pend);
            check("m_val",      l15_val, m_val);
            check("m_rqtype",   l15_rqtype, m_rq);
            check("m_addr",     l15_address, m_a);
            check("m_data",     l15_data, m_d);
            check("m_size",     l15_size, m_sz);
            check("m_overflow", overflow, m_ovf);
            check("m_fire",     resp_fire, (m_phase == 2) && l15_resp_val);
            if ((m_phase == 2) && l15_resp_val) check("m_src", resp_src, m_src);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_val(input string tag);
        int n = 0;
        while (!l15_val && n < 20) begin
            step();
            n++;
        end
        check({tag, "_issue"}, l15_val, 1'b1);
    endtask

    task automatic respond(input int src, input string tag);
        step();
        l15_resp_val = 1'b1;
        #1;
        check({tag, "_fire"}, resp_fire, 1'b1);
        check({tag, "_src"}, resp_src, src);
        step();
        l15_resp_val = 1'b0;
    endtask

    task automatic serve(input logic [4:0] rq, input logic [AW-1:0] a, input int src,
                         input bit resp, input string tag);
        wait_val(tag);
        check({tag, "_rqtype"}, l15_rqtype, rq);
        check({tag, "_addr"}, l15_address, a);
        l15_ack = 1'b1;
        step();
        l15_ack = 1'b0;
        check({tag, "_ackclr"}, l15_val, 1'b0);
        if (resp) respond(src, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        imiss_val = 0; ld_val = 0; st_val = 0;
        imiss_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0; st_size = 0;
        l15_ack = 0; l15_resp_val = 0;
        do_reset();
        check("rst_val", l15_val, 1'b0);
        check("rst_busy", {st_busy, ld_busy, imiss_busy}, 3'b000);
        check("rst_ovf", overflow, 3'b000);

        // Store: two cycles to issue, held until ack
        st_val = 1; st_addr = 40'h80_0000_1000; st_data = 64'h1122334455667788; st_size = 3'd3;
        step();
        st_val = 0;
        check("t1_busy", st_busy, 1'b1);
        check("t1_early", l15_val, 1'b0);
        step();
        check("t1_val", l15_val, 1'b1);
        check("t1_rq", l15_rqtype, RQ_STORE);
        check("t1_addr", l15_address, 40'h80_0000_1000);
        check("t1_data", l15_data, 64'h1122334455667788);
        check("t1_size", l15_size, 3'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_hold", {l15_val, l15_address}, {1'b1, 40'h80_0000_1000});
        end
        l15_ack = 1;
        step();
        l15_ack = 0;
        check("t1_ackval", l15_val, 1'b0);
        check("t1_ackbusy", st_busy, 1'b0);

        // Three sources at once: served I, L, S
        imiss_val = 1; imiss_addr = 40'h00_0000_0040;
        ld_val = 1; ld_addr = 40'h00_0000_0080;
        st_val = 1; st_addr = 40'h00_0000_00C0; st_data = 64'hA5; st_size = 3'd0;
        step();
        imiss_val = 0; ld_val = 0; st_val = 0;
        serve(RQ_IMISS, 40'h40, 0, 1, "t2_i");
        serve(RQ_LOAD,  40'h80, 1, 1, "t2_l");
        serve(RQ_STORE, 40'hC0, 2, 0, "t2_s");

        // I re-pulsed after every service alongside L: grants alternate
        imiss_val = 1; imiss_addr = 40'h100;
        ld_val = 1; ld_addr = 40'h200;
        step();
        imiss_val = 0; ld_val = 0;
        serve(RQ_IMISS, 40'h100, 0, 1, "t3_i0");
        imiss_val = 1; imiss_addr = 40'h101; step(); imiss_val = 0;
        serve(RQ_LOAD,  40'h200, 1, 1, "t3_l0");
        ld_val = 1; ld_addr = 40'h201; step(); ld_val = 0;
        serve(RQ_IMISS, 40'h101, 0, 1, "t3_i1");
        serve(RQ_LOAD,  40'h201, 1, 1, "t3_l1");

        // Back-to-back load pulses: second dropped
        do_reset();
        ld_val = 1; ld_addr = 40'h300;
        step();
        ld_addr = 40'h3FF;
        step();
        ld_val = 0;
        check("t4_ovf", overflow, 3'b010);
        serve(RQ_LOAD, 40'h300, 1, 1, "t4_l");
        repeat (3) step();
        check("t4_idle", l15_val, 1'b0);
        check("t4_ovf_sticky", overflow, 3'b010);

        // Load pulse coinciding with ack of the pending load
        ld_val = 1; ld_addr = 40'h400;
        step();
        ld_val = 0;
        wait_val("t5_a");
        check("t5_a_addr", l15_address, 40'h400);
        l15_ack = 1; ld_val = 1; ld_addr = 40'h480;
        step();
        l15_ack = 0; ld_val = 0;
        check("t5_busy", ld_busy, 1'b1);
        check("t5_ackval", l15_val, 1'b0);
        respond(1, "t5_a");
        serve(RQ_LOAD, 40'h480, 1, 1, "t5_b");

        // Reset mid-request, then stray ack/response while idle
        st_val = 1; st_addr = 40'h500; st_data = 64'hDEAD; st_size = 3'd2;
        step();
        st_val = 0;
        wait_val("t6_s");
        step();
        rst = 1;
        step();
        rst = 0;
        check("t6_val", l15_val, 1'b0);
        check("t6_busy", {st_busy, ld_busy, imiss_busy}, 3'b000);
        check("t6_ovf", overflow, 3'b000);
        l15_ack = 1; l15_resp_val = 1;
        step();
        check("t6_stray_fire", resp_fire, 1'b0);
        l15_ack = 0; l15_resp_val = 0;
        check("t6_stray_val", l15_val, 1'b0);
        imiss_val = 1; imiss_addr = 40'h600; st_val = 1; st_addr = 40'h700;
        step();
        imiss_val = 0; st_val = 0;
        serve(RQ_IMISS, 40'h600, 0, 1, "t6_i");
        serve(RQ_STORE, 40'h700, 2, 0, "t6_s2");

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/anycore_l15_req_arbiter.md
Name: anycore_l15_req_arbiter

Overview:
- Sequences AnyCore L1 miss/store traffic onto the single L1.5 transducer request port.
- Captures single-cycle request pulses from three requesters (I-cache miss, D-cache load, D-cache store) into per-source pending slots.
- Round-robin arbitrates among pending slots and holds the granted request on the L1.5 port until acknowledged.
- For ifill/load, blocks further issue until the L1.5 response returns; routes that response back to its source. Sits between the AnyCore core and the anycore decoder/L1.5 interface.

Parameters:
ADDR_W, 40, physical address width (matches PHY_ADDR_WIDTH)
DATA_W, 64, store data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imiss_val  in  1  I-cache miss request pulse
imiss_addr  in  ADDR_W  ifill physical address
imiss_busy  out  1  I slot pending
ld_val  in  1  D-cache load request pulse
ld_addr  in  ADDR_W  load physical address
ld_busy  out  1  L slot pending
st_val  in  1  store request pulse
st_addr  in  ADDR_W  store physical address
st_data  in  DATA_W  store data, already byte-ordered for L1.5
st_size  in  3  store PCX size code
st_busy  out  1  S slot pending
l15_val  out  1  request valid to L1.5
l15_rqtype  out  5  IMISS_RQ / LOAD_RQ / STORE_RQ (iop.h encodings)
l15_address  out  ADDR_W  request address
l15_data  out  DATA_W  store data, 0 otherwise
l15_size  out  3  PCX_SZ_4B for ifill/load, st_size for store
l15_ack  in  1  L1.5 accepted the request presented this cycle
l15_resp_val  in  1  L1.5 response valid
resp_fire  out  1  response belongs to outstanding ifill/load
resp_src  out  2  0=I, 1=L, 2=S (valid with resp_fire)
overflow  out  3  sticky {S,L,I}: pulse dropped because slot already pending

Behaviour:
- Reset (rst=1 at clk edge): all pending slots 0, state IDLE, l15_val=0, l15_rqtype/address/data/size=0, overflow=0, last-grant pointer=S (so I wins first), resp_fire=0.
- Slot capture: x_val=1 with slot x empty → next edge sets pending[x] and latches that source's addr/data/size. x_busy = pending[x] (registered).
- Slot clear: pending[x] clears on the edge where its request is acked.
- If x_val=1 in that same cycle, set wins: new request is captured, slot stays pending.
- x_val=1 while pending[x]=1 and not being cleared: pulse dropped; overflow[x] set, sticky until reset.
- State IDLE:
  - If any slot pending, grant the first pending slot after last-grant in order I→L→S→I.
  - Next edge: load l15_* from that slot, l15_val=1, state REQ, update last-grant.
  - A slot set in the same cycle is not visible until the following cycle.
- State REQ:
  - l15_val and all l15_* fields held stable until l15_ack=1.
  - On ack edge: l15_val=0, l15_* cleared to 0, pending cleared. Granted source I or L → WAIT; granted source S → IDLE.
- State WAIT:
  - l15_val=0. resp_fire = l15_resp_val (combinational), resp_src = granted source.
  - Edge with l15_resp_val=1 → IDLE.
- Ignored inputs: l15_ack outside REQ; l15_resp_val outside WAIT.
- Latency (pulse to l15_val): pulse at cycle 0 → pending at 1 → l15_val=1 at 2 (when IDLE and granted). Ack to next l15_val: at least 1 IDLE cycle for stores; for loads, response cycle plus 1.
- Strictly one outstanding L1.5 transaction at a time.
- Reset asserted mid-transaction: outstanding request abandoned; outputs return to reset values at the next edge.

Test Plan:
- Reset, st_val pulse with addr 0x80_0000_1000, data 0x1122334455667788, size 3 → l15_val=1 two cycles later with STORE_RQ and those values; held 5 cycles until ack; after ack l15_val=0, st_busy=0, state IDLE.
- imiss_val, ld_val, st_val in same cycle → grants I, L, S in order. Each ifill/load issue waits for l15_resp_val; resp_fire with resp_src 0, then 1.
- I pending continuously re-pulsed alongside L → grants alternate I, L, I, L (round-robin fairness, no starvation).
- Two ld_val pulses 1 cycle apart → second dropped, overflow=3'b010 sticky, only one LOAD_RQ issued.
- ld_val pulse in same cycle as ack of the pending load → ld_busy stays 1, a second LOAD_RQ carries the new address.
- rst=1 while in REQ with l15_val=1 → next cycle l15_val=0, all busy=0, overflow=0. Stray l15_ack/l15_resp_val in IDLE → no effect.
